tlc_phase_arbiter: RTL and testbench

Four-phase green-time arbiter for the traffic-light controller: it shares the intersection's single "green" right-of-way among four approach phases (N, S, E, W). It latches vehicle-detector requests and grants green round-robin under minimum and maximum green timers. Every handover passes through yellow and all-red clearance. An emergency preempt input forces a chosen phase. Its outputs drive the lamp drivers directly.

---
 rtl/tlc_pkg.sv | 39 +++
 rtl/tlc_rr_picker.sv | 39 +++
 rtl/tlc_phase_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_tlc_phase_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// ----------------------------------------------------------------------------
// tlc_pkg
// Shared definitions for the traffic-light controller blocks.
//
// Contents:
//   - NUM_PHASES / PHASE_W   : four approach phases, 2-bit phase index
//   - STATE_* localparams    : lamp-state encoding as presented on o_state
//   - tlc_state_e            : FSM state type built on that encoding
//   - DEF_* constants        : default green / yellow / all-red timings
//   - phase_onehot()         : phase index -> one-hot lamp vector
// ----------------------------------------------------------------------------
package tlc_pkg;

    localparam int unsigned NUM_PHASES = 4;
    localparam int unsigned PHASE_W    = 2;

    // Encoding is visible outside the block on o_state, so it is pinned here.
    localparam logic [1:0] STATE_GREEN   = 2'd0;
    localparam logic [1:0] STATE_YELLOW  = 2'd1;
    localparam logic [1:0] STATE_ALL_RED = 2'd2;

    typedef enum logic [1:0] {
        ST_GREEN   = STATE_GREEN,
        ST_YELLOW  = STATE_YELLOW,
        ST_ALL_RED = STATE_ALL_RED
    } tlc_state_e;

    localparam int unsigned DEF_MIN_GREEN = 10;
    localparam int unsigned DEF_MAX_GREEN = 25;
    localparam int unsigned DEF_YELLOW_T  = 4;
    localparam int unsigned DEF_ALLRED_T  = 2;
    localparam int unsigned DEF_CNT_W     = 10;

    // One-hot lamp pattern for a phase index (phase 0 -> bit 0).
    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [PHASE_W-1:0] phase);
        return NUM_PHASES'(1) << phase;
    endfunction

endpackage : tlc_pkg

// File: rtl/tlc_rr_picker.sv
// ----------------------------------------------------------------------------
// tlc_rr_picker
// Combinational round-robin search. Starting one past the current phase and
// wrapping modulo NUM_PHASES, returns the first phase whose pending bit is
// set. The current phase itself is never considered, so a phase that keeps
// asking cannot starve the others.
//
// Ports:
//   pending_i     in  NUM_PHASES  latched requests per phase
//   phase_i       in  PHASE_W     phase currently (or last) granted
//   found_o       out 1           some other phase is pending
//   next_phase_o  out PHASE_W     chosen phase; equals phase_i when !found_o
// ----------------------------------------------------------------------------
module tlc_rr_picker
    import tlc_pkg::*;
(
    input  logic [NUM_PHASES-1:0] pending_i,
    input  logic [PHASE_W-1:0]    phase_i,
    output logic                  found_o,
    output logic [PHASE_W-1:0]    next_phase_o
);

    // Scan offsets 1..NUM_PHASES-1; the first hit wins. The 2-bit add wraps
    // naturally, which gives the modulo-4 search order for free.
    always_comb begin : search
        logic [PHASE_W-1:0] candidate;
        candidate    = phase_i;
        found_o      = 1'b0;
        next_phase_o = phase_i;
        for (int k = 1; k < NUM_PHASES; k++) begin
            candidate = phase_i + PHASE_W'(k);
            if (!found_o && pending_i[candidate]) begin
                found_o      = 1'b1;
                next_phase_o = candidate;
            end
        end
    end

endmodule : tlc_rr_picker

// File: rtl/tlc_phase_arbiter.sv
// ----------------------------------------------------------------------------
// tlc_phase_arbiter
// Four-phase green-time arbiter. Latches vehicle-detector requests, grants the
// single green right-of-way round-robin under minimum / maximum green timers,
// routes every handover through YELLOW and ALL_RED clearance, and honours an
// emergency preempt that forces a chosen phase. All outputs are registered so
// they can drive the lamp drivers directly.
//
// Parameters:
//   MIN_GREEN  minimum green cycles per grant (unless preempted)
//   MAX_GREEN  maximum green cycles while another phase is pending
//   YELLOW_T   yellow duration in cycles
//   ALLRED_T   all-red clearance duration in cycles
//   CNT_W      state-timer width, must hold MAX_GREEN
//
// Ports:
//   i_clk            in   1  clock
//   i_rst_n          in   1  asynchronous active-low reset
//   i_req            in   4  vehicle-detect level per phase
//   i_preempt        in   1  emergency preempt request (level)
//   i_preempt_phase  in   2  phase to force while i_preempt is high
//   o_green          out  4  one-hot green lamp, zero outside GREEN
//   o_yellow         out  4  outgoing phase bit during YELLOW
//   o_red            out  4  ~(o_green | o_yellow)
//   o_phase          out  2  current or last-granted phase
//   o_state          out  2  GREEN=0, YELLOW=1, ALL_RED=2
//   o_pending        out  4  latched, unserved requests
// ----------------------------------------------------------------------------
module tlc_phase_arbiter
    import tlc_pkg::*;
#(
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_PHASES-1:0] i_req,
    input  logic                  i_preempt,
    input  logic [PHASE_W-1:0]    i_preempt_phase,
    output logic [NUM_PHASES-1:0] o_green,
    output logic [NUM_PHASES-1:0] o_yellow,
    output logic [NUM_PHASES-1:0] o_red,
    output logic [PHASE_W-1:0]    o_phase,
    output logic [1:0]            o_state,
    output logic [NUM_PHASES-1:0] o_pending
);

    // Exit thresholds: each condition is tested on the cycle where the timer
    // reads N-1, so the new state appears after exactly N cycles.
    localparam logic [CNT_W-1:0] MIN_LIM   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM   = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LIM    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] TIMER_SAT = {CNT_W{1'b1}};

    localparam logic [NUM_PHASES-1:0] RESET_GREEN = NUM_PHASES'(1);

    tlc_state_e              state_q,   state_d;
    logic [PHASE_W-1:0]      phase_q,   phase_d;
    logic [CNT_W-1:0]        timer_q,   timer_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic [NUM_PHASES-1:0]   green_q,   green_d;
    logic [NUM_PHASES-1:0]   yellow_q,  yellow_d;
    logic [NUM_PHASES-1:0]   red_q,     red_d;

    logic [NUM_PHASES-1:0]   phaseMask;
    logic [NUM_PHASES-1:0]   greenMask;
    logic [NUM_PHASES-1:0]   nextMask;
    logic                    others;
    logic                    gapOut;
    logic                    maxOut;
    logic                    rrFound;
    logic [PHASE_W-1:0]      rrPhase;
    logic                    enterGreen;

    tlc_rr_picker u_rr_picker (
        .pending_i    (pending_q),
        .phase_i      (phase_q),
        .found_o      (rrFound),
        .next_phase_o (rrPhase)
    );

    // Gap-out and max-out only count as reasons to leave when somebody else
    // is actually waiting; with nobody else waiting the phase rests in green.
    always_comb begin
        phaseMask = phase_onehot(phase_q);
        others    = |(pending_q & ~phaseMask);
        gapOut    = (timer_q >= MIN_LIM) && others && !i_req[phase_q];
        maxOut    = (timer_q >= MAX_LIM) && others;
    end

    // Next-state logic. A preempt naming the green phase pins it in green and
    // masks the timers; a preempt naming any other phase ends green at once.
    // Yellow is never shortened. The phase only changes on leaving ALL_RED,
    // where preempt overrides the round-robin pick, and an empty search
    // returns green to the same phase.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        enterGreen = 1'b0;
        unique case (state_q)
            ST_GREEN: begin
                if (i_preempt) begin
                    if (i_preempt_phase != phase_q) begin
                        state_d = ST_YELLOW;
                    end
                end else if (gapOut || maxOut) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (timer_q == YEL_LIM) begin
                    state_d = ST_ALL_RED;
                end
            end
            ST_ALL_RED: begin
                if (timer_q == AR_LIM) begin
                    state_d    = ST_GREEN;
                    enterGreen = 1'b1;
                    if (i_preempt) begin
                        phase_d = i_preempt_phase;
                    end else if (rrFound) begin
                        phase_d = rrPhase;
                    end
                end
            end
            default: begin
                state_d = ST_GREEN;
            end
        endcase
    end

    // Timer restarts on every state change and otherwise counts up, holding
    // at all-ones so an idle green rest cannot wrap back under MIN_GREEN.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_SAT) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    // Requests latch for any phase that is not currently showing green
    // (during YELLOW/ALL_RED nobody holds green, so every request latches).
    // The bit of the phase about to go green is cleared last, so a request
    // arriving on the grant edge is absorbed by the grant itself.
    always_comb begin
        greenMask = (state_q == ST_GREEN) ? phaseMask : '0;
        pending_d = pending_q | (i_req & ~greenMask);
        if (enterGreen) begin
            pending_d = pending_d & ~phase_onehot(phase_d);
        end
    end

    // Lamp outputs are decoded from the next state so that they register on
    // the same edge as the state itself, with no input-to-output path.
    always_comb begin
        nextMask = phase_onehot(phase_d);
        green_d  = (state_d == ST_GREEN)  ? nextMask : '0;
        yellow_d = (state_d == ST_YELLOW) ? nextMask : '0;
        red_d    = ~(green_d | yellow_d);
    end

    // State, timer, pending and lamp registers; reset leaves phase 0 green.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_GREEN;
            phase_q   <= '0;
            timer_q   <= '0;
            pending_q <= '0;
            green_q   <= RESET_GREEN;
            yellow_q  <= '0;
            red_q     <= ~RESET_GREEN;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            red_q     <= red_d;
        end
    end

    assign o_green   = green_q;
    assign o_yellow  = yellow_q;
    assign o_red     = red_q;
    assign o_phase   = phase_q;
    assign o_state   = state_q;
    assign o_pending = pending_q;

endmodule : tlc_phase_arbiter

// File: tb/tb_tlc_phase_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tlc_phase_arbiter
// Scoreboard bench for tlc_phase_arbiter. A stimulus process drives inputs on
// the falling edge, advances a behavioural reference model by one cycle and
// queues the expected post-edge outputs; a monitor pops one entry after each
// rising edge and compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_tlc_phase_arbiter;

    localparam int MIN_G  = 10;
    localparam int MAX_G  = 25;
    localparam int YEL_T  = 4;
    localparam int AR_T   = 2;
    localparam int CNT_W  = 10;
    localparam int SAT    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0] green;
        logic [3:0] yellow;
        logic [3:0] red;
        logic [1:0] phase;
        logic [1:0] state;
        logic [3:0] pending;
    } obs_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] req;
    logic       pre;
    logic [1:0] prePhase;
    logic [3:0] green, yellow, red, pending;
    logic [1:0] phase, state;

    int checks = 0;
    int errors = 0;

    obs_t expQ[$];

    // Reference model: lamp state (0 green, 1 yellow, 2 all-red), granted
    // phase, cycles spent in the current state, and latched requests.
    int         mState;
    int         mPhase;
    int         mDwell;
    logic [3:0] mPending;

    always #5 clk = ~clk;

    tlc_phase_arbiter #(
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_T  (YEL_T),
        .ALLRED_T  (AR_T),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rstN),
        .i_req           (req),
        .i_preempt       (pre),
        .i_preempt_phase (prePhase),
        .o_green         (green),
        .o_yellow        (yellow),
        .o_red           (red),
        .o_phase         (phase),
        .o_state         (state),
        .o_pending       (pending)
    );

    task automatic modelReset();
        mState   = 0;
        mPhase   = 0;
        mDwell   = 0;
        mPending = 4'b0000;
    endtask

    function automatic obs_t modelOutputs();
        obs_t o;
        o.green   = (mState == 0) ? 4'(1 << mPhase) : 4'b0000;
        o.yellow  = (mState == 1) ? 4'(1 << mPhase) : 4'b0000;
        o.red     = ~(o.green | o.yellow);
        o.phase   = 2'(mPhase);
        o.state   = 2'(mState);
        o.pending = mPending;
        return o;
    endfunction

    // One clock of the intersection rules: the old pending set decides who
    // waits and who is picked; new requests latch unless that phase is green;
    // the phase receiving green has its request cleared.
    task automatic modelStep(input logic [3:0] r, input logic p, input logic [1:0] pp);
        int         nState;
        int         nPhase;
        bit         someoneElse;
        bit         leaveGreen;
        logic [3:0] latched;
        nState      = mState;
        nPhase      = mPhase;
        someoneElse = 1'b0;
        for (int k = 0; k < 4; k++)
            if (k != mPhase && mPending[k]) someoneElse = 1'b1;
        latched = mPending;
        for (int k = 0; k < 4; k++)
            if (r[k] && !(mState == 0 && k == mPhase)) latched[k] = 1'b1;
        if (mState == 0) begin
            if (p) leaveGreen = (int'(pp) != mPhase);
            else   leaveGreen = someoneElse &&
                                ((mDwell + 1 >= MIN_G && !r[mPhase]) || mDwell + 1 >= MAX_G);
            if (leaveGreen) nState = 1;
        end else if (mState == 1) begin
            if (mDwell + 1 == YEL_T) nState = 2;
        end else begin
            if (mDwell + 1 == AR_T) begin
                nState = 0;
                if (p) nPhase = int'(pp);
                else begin
                    for (int k = 1; k < 4; k++) begin
                        if (mPending[(mPhase + k) % 4]) begin
                            nPhase = (mPhase + k) % 4;
                            break;
                        end
                    end
                end
                latched[nPhase] = 1'b0;
            end
        end
        if (nState != mState) mDwell = 0;
        else if (mDwell < SAT) mDwell = mDwell + 1;
        mState   = nState;
        mPhase   = nPhase;
        mPending = latched;
    endtask

    function automatic obs_t sampleDut();
        obs_t o;
        o.green   = green;
        o.yellow  = yellow;
        o.red     = red;
        o.phase   = phase;
        o.state   = state;
        o.pending = pending;
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s t=%0t got g=%b y=%b r=%b ph=%0d st=%0d pend=%b expected g=%b y=%b r=%b ph=%0d st=%0d pend=%b",
                     name, $time, got.green, got.yellow, got.red, got.phase, got.state, got.pending,
                     want.green, want.yellow, want.red, want.phase, want.state, want.pending);
        end
    endtask

    // Drive one input pattern for n cycles, queueing the model's prediction.
    task automatic applyStimulus(input logic [3:0] r, input logic p, input logic [1:0] pp, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstN     = 1'b1;
            req      = r;
            pre      = p;
            prePhase = pp;
            modelStep(r, p, pp);
            expQ.push_back(modelOutputs());
        end
    endtask

    // Assert reset between edges: the outputs must return to the reset
    // values straight away, not on the next clock.
    task automatic applyReset(input int n);
        obs_t resetVals;
        @(negedge clk);
        rstN = 1'b0;
        req  = 4'b0000;
        pre  = 1'b0;
        modelReset();
        resetVals = modelOutputs();
        #1;
        checkOutput("async_reset", sampleDut(), resetVals);
        expQ.push_back(resetVals);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            expQ.push_back(resetVals);
        end
    endtask

    // Monitor: every rising edge produces one output word to score.
    initial begin : monitor
        obs_t want;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                checkOutput("scoreboard", sampleDut(), want);
            end
        end
    end

    initial begin : stimulus
        int         guard;
        int         burst;
        logic [3:0] rndReq;
        logic [1:0] rndPhase;
        rstN     = 1'b0;
        req      = 4'b0000;
        pre      = 1'b0;
        prePhase = 2'd0;
        modelReset();

        $display("[TB] idle rest");
        applyReset(2);
        applyStimulus(4'b0000, 1'b0, 2'd0, 100);

        $display("[TB] single request gap-out");
        applyReset(2);
        applyStimulus(4'b0100, 1'b0, 2'd0, 30);

        $display("[TB] all requests max-out rotation");
        applyReset(2);
        applyStimulus(4'b1111, 1'b0, 2'd0, 140);

        $display("[TB] preempt to phase 2");
        applyReset(2);
        applyStimulus(4'b0000, 1'b0, 2'd0, 3);
        applyStimulus(4'b1111, 1'b1, 2'd2, 45);
        applyStimulus(4'b1111, 1'b0, 2'd0, 40);

        $display("[TB] reset during yellow");
        applyReset(2);
        guard = 0;
        while (mState != 1 && guard < 60) begin
            applyStimulus(4'b0100, 1'b0, 2'd0, 1);
            guard++;
        end
        applyStimulus(4'b0100, 1'b0, 2'd0, 1);
        applyReset(2);
        applyStimulus(4'b0000, 1'b0, 2'd0, 30);

        $display("[TB] wrap past phase 0");
        applyReset(2);
        applyStimulus(4'b1000, 1'b0, 2'd0, 2);
        applyStimulus(4'b0000, 1'b0, 2'd0, 20);
        applyStimulus(4'b0010, 1'b0, 2'd0, 3);
        applyStimulus(4'b0000, 1'b0, 2'd0, 25);

        $display("[TB] randomized traffic");
        rndReq   = 4'b0000;
        rndPhase = 2'd0;
        burst    = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) rndReq = 4'($urandom_range(0, 15));
            if (burst == 0 && $urandom_range(0, 119) == 0) begin
                burst    = $urandom_range(3, 40);
                rndPhase = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 599) == 0) applyReset($urandom_range(1, 3));
            applyStimulus(rndReq, burst > 0, rndPhase, 1);
            if (burst > 0) burst--;
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d queued expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tlc_phase_arbiter
